// File: rtl/nn_pkg.sv
// Shared constants and FSM encoding for the digit-recognition pixel feeder.
// Everything that sits upstream of the nn core imports this package.
package nn_pkg;

  localparam int NN_BITS           = 24;
  localparam int NN_PIXELS         = 784;
  localparam int NN_CNT_W          = 10;
  localparam int NN_FIFO_DEPTH     = 16;
  localparam int NN_RESULT_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } nn_state_t;

endpackage

// File: rtl/nn_pixel_fifo.sv
// Small synchronous pixel FIFO with a registered ready flag and a flush input.
// There is no bypass path: a word written into an empty FIFO is poppable next cycle.
module nn_pixel_fifo
  import nn_pkg::*;
#(
  parameter int BITS       = NN_BITS,
  parameter int FIFO_DEPTH = NN_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_push,
  input  logic [BITS-1:0] i_data,
  input  logic            i_pop,
  output logic [BITS-1:0] o_data,
  output logic            o_ready,
  output logic            o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ready;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;

  assign w_push = i_push && r_ready;
  assign w_pop  = i_pop && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Ready is registered from the next occupancy, so it reflects !full without any
  // combinational dependence on this cycle's pop; it stays low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_ready = r_ready;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/nn_pixel_feeder.sv
// Sequences one frame of buffered pixels into the nn core, then captures its prediction
// a fixed number of cycles after the last pixel has been presented.
module nn_pixel_feeder
  import nn_pkg::*;
#(
  parameter int BITS           = NN_BITS,
  parameter int NUM_PIXELS     = NN_PIXELS,
  parameter int CNT_W          = NN_CNT_W,
  parameter int FIFO_DEPTH     = NN_FIFO_DEPTH,
  parameter int RESULT_LATENCY = NN_RESULT_LATENCY
) (
  input  logic             up_clk,
  input  logic             up_rstn,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [BITS-1:0]  in_pixel,
  output logic             in_ready,
  output logic [CNT_W-1:0] pixel_counter,
  output logic [BITS-1:0]  input_pixel,
  output logic             pixel_valid,
  input  logic [BITS-1:0]  predict_num,
  output logic [BITS-1:0]  result,
  output logic             result_valid,
  output logic             busy
);

  localparam int LAT_W = $clog2(RESULT_LATENCY + 1);

  nn_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_idx, w_idx_nxt;
  logic [LAT_W-1:0] r_lat_cnt, w_lat_nxt;
  logic [CNT_W-1:0] r_pixel_counter, w_pc_nxt;
  logic [BITS-1:0]  r_input_pixel, w_px_nxt;
  logic             r_pixel_valid, w_pv_nxt;
  logic [BITS-1:0]  r_result, w_res_nxt;
  logic             r_result_valid, w_rv_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_pop;
  logic [BITS-1:0]  w_fifo_data;
  logic             w_fifo_empty;
  logic             w_fifo_ready;

  nn_pixel_fifo #(
    .BITS       (BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (up_clk),
    .rst_n   (up_rstn),
    .i_clear (clear),
    .i_push  (in_valid),
    .i_data  (in_pixel),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_ready (w_fifo_ready),
    .o_empty (w_fifo_empty)
  );

  // The pixel outputs default to the out-of-range sentinel every cycle, so the core
  // only ever sees a real index on cycles where a pixel was actually popped.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_lat_nxt   = r_lat_cnt;
    w_pc_nxt    = CNT_W'(NUM_PIXELS);
    w_px_nxt    = '0;
    w_pv_nxt    = 1'b0;
    w_res_nxt   = r_result;
    w_rv_nxt    = r_result_valid;
    w_pop       = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_STREAM;
          w_idx_nxt   = '0;
          w_rv_nxt    = 1'b0;
        end
      end
      ST_STREAM: begin
        if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          w_pc_nxt  = r_idx;
          w_px_nxt  = w_fifo_data;
          w_pv_nxt  = 1'b1;
          w_idx_nxt = r_idx + CNT_W'(1);
          if (r_idx == CNT_W'(NUM_PIXELS - 1)) begin
            w_state_nxt = ST_WAIT;
            w_lat_nxt   = '0;
          end
        end
      end
      ST_WAIT: begin
        w_lat_nxt = r_lat_cnt + LAT_W'(1);
        if (r_lat_cnt == LAT_W'(RESULT_LATENCY - 1)) begin
          w_res_nxt   = predict_num;
          w_rv_nxt    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_lat_nxt   = '0;
      w_pc_nxt    = CNT_W'(NUM_PIXELS);
      w_px_nxt    = '0;
      w_pv_nxt    = 1'b0;
      w_res_nxt   = '0;
      w_rv_nxt    = 1'b0;
      w_pop       = 1'b0;
    end

    w_busy_nxt = (w_state_nxt == ST_STREAM) || (w_state_nxt == ST_WAIT);
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      r_state         <= ST_IDLE;
      r_idx           <= '0;
      r_lat_cnt       <= '0;
      r_pixel_counter <= CNT_W'(NUM_PIXELS);
      r_input_pixel   <= '0;
      r_pixel_valid   <= 1'b0;
      r_result        <= '0;
      r_result_valid  <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_idx           <= w_idx_nxt;
      r_lat_cnt       <= w_lat_nxt;
      r_pixel_counter <= w_pc_nxt;
      r_input_pixel   <= w_px_nxt;
      r_pixel_valid   <= w_pv_nxt;
      r_result        <= w_res_nxt;
      r_result_valid  <= w_rv_nxt;
      r_busy          <= w_busy_nxt;
    end
  end

  assign in_ready      = w_fifo_ready;
  assign pixel_counter = r_pixel_counter;
  assign input_pixel   = r_input_pixel;
  assign pixel_valid   = r_pixel_valid;
  assign result        = r_result;
  assign result_valid  = r_result_valid;
  assign busy          = r_busy;

endmodule

// File: tb/tb_nn_pixel_feeder.sv
// Directed bench for nn_pixel_feeder: streams whole frames, aborts, back-to-back runs.
// Pixel values are 0x100 + their position in the pushed stream, so data order is self-evident.
module tb_nn_pixel_feeder;
  import nn_pkg::*;

  logic                up_clk;
  logic                up_rstn;
  logic                start;
  logic                clear;
  logic                in_valid;
  logic [NN_BITS-1:0]  in_pixel;
  logic                in_ready;
  logic [NN_CNT_W-1:0] pixel_counter;
  logic [NN_BITS-1:0]  input_pixel;
  logic                pixel_valid;
  logic [NN_BITS-1:0]  predict_num;
  logic [NN_BITS-1:0]  result;
  logic                result_valid;
  logic                busy;

  nn_pixel_feeder dut (
    .up_clk        (up_clk),
    .up_rstn       (up_rstn),
    .start         (start),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_pixel      (in_pixel),
    .in_ready      (in_ready),
    .pixel_counter (pixel_counter),
    .input_pixel   (input_pixel),
    .pixel_valid   (pixel_valid),
    .predict_num   (predict_num),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy)
  );

  initial up_clk = 1'b0;
  always #5 up_clk = ~up_clk;

  int checkCount;
  int passCount;
  int failCount;
  int pushCount;
  int nextPop;

  int pvCount, idxErr, dataErr, gapErr, gapCount, busyErr, rvErr;
  int firstPvIter, latency, timedOut;
  logic rdy1, rdy2;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Starts a frame from the current drive phase and runs it cycle by cycle.
  // abortMode 1/2 returns once abortIdx pixels have been seen, leaving the caller to abort.
  task automatic applyStimulus(input int feedPeriod, input int pushLimit, input int abortIdx,
                               input int abortMode, input int ignoreIdx);
    int  iter;
    int  expIdx;
    int  lastIter;
    bit  done;
    bit  pulsedA;
    pvCount = 0; idxErr = 0; dataErr = 0; gapErr = 0; gapCount = 0; busyErr = 0; rvErr = 0;
    firstPvIter = -1; latency = -1; timedOut = 0; rdy1 = 1'bx; rdy2 = 1'bx;
    iter = 0; expIdx = 0; lastIter = -1; done = 0; pulsedA = 0;
    start = 1'b1;
    while (iter < 4000 && !done) begin
      @(posedge up_clk); #1;
      iter++;
      if (iter == 1) rdy1 = in_ready;
      if (iter == 2) rdy2 = in_ready;
      if (pixel_valid === 1'b1) begin
        if (firstPvIter < 0) firstPvIter = iter;
        if (pixel_counter !== NN_CNT_W'(expIdx)) idxErr++;
        if (input_pixel !== NN_BITS'(32'h100 + nextPop)) dataErr++;
        if (expIdx == NN_PIXELS - 1) lastIter = iter;
        expIdx++; nextPop++; pvCount++;
      end else begin
        if (pixel_counter !== NN_CNT_W'(NN_PIXELS) || input_pixel !== '0) gapErr++;
        if (firstPvIter >= 0 && lastIter < 0) gapCount++;
      end
      if (result_valid === 1'b1 && lastIter >= 0) begin
        latency = iter - lastIter;
        if (busy !== 1'b0) busyErr++;
        start = 1'b0; in_valid = 1'b0;
        done = 1;
      end else begin
        if (result_valid !== 1'b0) rvErr++;
        if (busy !== 1'b1) busyErr++;
        if (abortMode != 0 && expIdx == abortIdx) begin
          done = 1;
        end else begin
          start = 1'b0;
          if (ignoreIdx >= 0 && expIdx == ignoreIdx && !pulsedA) begin
            start = 1'b1; pulsedA = 1;
          end
          if (ignoreIdx >= 0 && lastIter == iter) start = 1'b1;
          if (pushCount < pushLimit && (iter % feedPeriod) == 0) begin
            in_valid = 1'b1;
            in_pixel = NN_BITS'(32'h100 + pushCount);
          end else begin
            in_valid = 1'b0;
          end
          if (in_valid && in_ready) pushCount++;
        end
      end
    end
    if (!done) timedOut = 1;
  endtask

  task automatic checkFrame(input string tag, input int expGaps, input logic [31:0] expResult);
    checkOutput({tag, " timeout"}, timedOut, 0);
    checkOutput({tag, " pixel count"}, pvCount, NN_PIXELS);
    checkOutput({tag, " index errors"}, idxErr, 0);
    checkOutput({tag, " data errors"}, dataErr, 0);
    checkOutput({tag, " gap sentinel errors"}, gapErr, 0);
    checkOutput({tag, " gap cycles"}, gapCount, expGaps);
    checkOutput({tag, " busy errors"}, busyErr, 0);
    checkOutput({tag, " early result_valid"}, rvErr, 0);
    checkOutput({tag, " result latency"}, latency, NN_RESULT_LATENCY);
    checkOutput({tag, " result"}, result, expResult);
  endtask

  initial begin
    checkCount = 0; passCount = 0; failCount = 0; pushCount = 0; nextPop = 0;
    up_rstn = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_pixel = '0;
    predict_num = 24'h000007;
    #22;
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset pixel_counter", pixel_counter, NN_PIXELS);
    checkOutput("reset input_pixel", input_pixel, 0);
    checkOutput("reset pixel_valid", pixel_valid, 0);
    checkOutput("reset result", result, 0);
    checkOutput("reset result_valid", result_valid, 0);
    checkOutput("reset busy", busy, 0);
    up_rstn = 1'b1;
    @(posedge up_clk); #1;
    checkOutput("in_ready after reset", in_ready, 1);

    // Preload without start: only FIFO_DEPTH pushes may be accepted.
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_pixel = NN_BITS'(32'h100 + pushCount);
      if (in_ready) pushCount++;
      @(posedge up_clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("preload pushes", pushCount, NN_FIFO_DEPTH);
    checkOutput("preload in_ready", in_ready, 0);
    checkOutput("preload pixel_valid", pixel_valid, 0);
    checkOutput("preload busy", busy, 0);

    applyStimulus(1, NN_PIXELS, -1, 0, -1);
    checkFrame("f1", 0, 24'h000007);
    checkOutput("f1 first pixel cycle", firstPvIter, 2);
    checkOutput("f1 in_ready before pop", rdy1, 0);
    checkOutput("f1 in_ready after pop", rdy2, 1);

    applyStimulus(3, pushCount + NN_PIXELS, -1, 0, -1);
    checkFrame("f2", 2 * (NN_PIXELS - 1), 24'h000007);

    applyStimulus(1, pushCount + NN_PIXELS, -1, 0, 400);
    checkFrame("f3", 0, 24'h000007);
    repeat (5) begin @(posedge up_clk); #1; end
    checkOutput("f3 done result_valid", result_valid, 1);
    checkOutput("f3 done busy", busy, 0);
    checkOutput("f3 done pixel_valid", pixel_valid, 0);

    applyStimulus(1, pushCount + NN_PIXELS, 500, 1, -1);
    checkOutput("f4 pixels before clear", pvCount, 500);
    checkOutput("f4 index errors", idxErr, 0);
    checkOutput("f4 data errors", dataErr, 0);
    clear = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(posedge up_clk); #1;
    clear = 1'b0;
    nextPop = pushCount;
    checkOutput("clear pixel_valid", pixel_valid, 0);
    checkOutput("clear pixel_counter", pixel_counter, NN_PIXELS);
    checkOutput("clear input_pixel", input_pixel, 0);
    checkOutput("clear busy", busy, 0);
    checkOutput("clear result_valid", result_valid, 0);
    checkOutput("clear in_ready", in_ready, 1);

    applyStimulus(1, pushCount + NN_PIXELS, -1, 0, -1);
    checkFrame("f5", 0, 24'h000007);

    applyStimulus(1, pushCount + NN_PIXELS, 300, 2, -1);
    checkOutput("f6 pixels before reset", pvCount, 300);
    start = 1'b0; in_valid = 1'b0;
    #2 up_rstn = 1'b0;
    #1;
    checkOutput("async reset pixel_valid", pixel_valid, 0);
    checkOutput("async reset pixel_counter", pixel_counter, NN_PIXELS);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset result", result, 0);
    checkOutput("async reset in_ready", in_ready, 0);
    @(posedge up_clk); @(posedge up_clk);
    #3 up_rstn = 1'b1;
    @(posedge up_clk); #1;
    nextPop = pushCount;

    applyStimulus(1, pushCount + NN_PIXELS, -1, 0, -1);
    checkFrame("f7", 0, 24'h000007);

    applyStimulus(1, pushCount + NN_PIXELS + 5, -1, 0, -1);
    checkFrame("f8", 0, 24'h000007);
    predict_num = 24'h000055;
    applyStimulus(1, pushCount + NN_PIXELS - 5, -1, 0, -1);
    checkFrame("f9", 0, 24'h000055);
    checkOutput("f9 first pixel cycle", firstPvIter, 2);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/nn_pixel_feeder.md
Name: nn_pixel_feeder

Overview:
- Upstream stage of the digit-recognition network: sequences one 784-pixel frame into the nn core's pixel_counter/input_pixel inputs.
- Pixels arrive on a valid/ready stream from the AXI register bank or a DMA and are buffered in a small FIFO.
- After the last pixel of a frame, waits a fixed core latency, then captures predict_num into a result register.
- Replaces per-pixel software register pokes with a single start command.

Parameters:
- BITS, 24, pixel and result word width
- NUM_PIXELS, 784, pixels per frame
- CNT_W, 10, pixel_counter width; must satisfy 2^CNT_W > NUM_PIXELS
- FIFO_DEPTH, 16, input buffer entries; power of two, at least 2
- RESULT_LATENCY, 4, cycles from the last pixel driven to predict_num being valid; at least 1

Ports:
- up_clk  in  1  clock
- up_rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame
- clear  in  1  synchronous abort; flushes FIFO and state
- in_valid  in  1  input pixel valid
- in_pixel  in  BITS  input pixel data
- in_ready  out  1  FIFO can accept a pixel
- pixel_counter  out  CNT_W  to nn pixel_counter
- input_pixel  out  BITS  to nn input_pixel
- pixel_valid  out  1  pixel_counter/input_pixel carry a real pixel this cycle
- predict_num  in  BITS  from nn
- result  out  BITS  captured prediction
- result_valid  out  1  result holds a completed frame's prediction
- busy  out  1  high in STREAM or WAIT

Behaviour:
- Reset (async, up_rstn=0): FSM=IDLE, FIFO empty, pixel_counter=NUM_PIXELS (sentinel 784), input_pixel=0, pixel_valid=0, result=0, result_valid=0, busy=0, in_ready=0 while reset is held.
- All outputs are registered.
- FIFO:
  - in_ready = !full. A push happens on in_valid && in_ready.
  - in_ready does not depend on a same-cycle pop.
  - No bypass: a pixel pushed into an empty FIFO can be popped no earlier than the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
  - A simultaneous push and pop leaves occupancy unchanged.
  - Pushes are accepted in every FSM state, so the next frame can be preloaded.
- FSM states:
  - IDLE: start goes to STREAM with pixel index idx=0 and result_valid cleared.
  - STREAM: each cycle the FIFO is non-empty, pop one entry. Next cycle: pixel_counter=idx, input_pixel=data, pixel_valid=1, idx++. If the FIFO is empty: pixel_valid=0, pixel_counter=NUM_PIXELS, input_pixel=0 (the stall is tolerated). When the pixel with idx=NUM_PIXELS-1 is popped, go to WAIT with lat_cnt=0.
  - WAIT: lat_cnt increments each cycle. At lat_cnt=RESULT_LATENCY-1, result<=predict_num, result_valid<=1, go to DONE.
  - DONE: result and result_valid hold. start clears result_valid and goes to STREAM with idx=0.
- Whenever pixel_valid=0, pixel_counter=NUM_PIXELS and input_pixel=0, so the nn core sees an out-of-range index.
- start is ignored in STREAM and WAIT.
- clear (priority over start): same-cycle effect equals reset, except in_ready follows !full (FIFO is now empty, so in_ready=1 next cycle).
- idx never exceeds NUM_PIXELS-1 while pixel_valid=1. Pixels in excess of one frame stay in the FIFO for the next frame.
- Latency, best case (FIFO preloaded): start at cycle 0 → first pixel_valid at cycle 2 → last pixel at cycle 785 → result_valid at cycle 785+RESULT_LATENCY.

Decomposition:
- Package nn_pkg: NN_BITS=24, NN_PIXELS=784, NN_CNT_W=10, NN_RESULT_LATENCY, and the FSM state encoding (IDLE=0, STREAM=1, WAIT=2, DONE=3).
- One sub-module: nn_pixel_fifo, a synchronous FIFO with async active-low reset, push/pop/full/empty, parameterised by BITS and FIFO_DEPTH.
- FSM, index counter and result capture live in the top level.

Test Plan:
- Preload 16 pixels of value 0x000100+i, pulse start, then keep the stream saturated → pixel_counter 0..783 on consecutive cycles, input_pixel matches each pushed value, result_valid rises exactly RESULT_LATENCY cycles after pixel_counter=783, result equals the predict_num stub value 0x000007.
- Feed a pixel every 3rd cycle → pixel_valid gaps with pixel_counter=784 and input_pixel=0 during the gaps, no index skipped or repeated, and the frame completes at idx 783.
- Hold in_valid=1 with start never asserted → exactly 16 pushes accepted, then in_ready=0. Pulse start → in_ready returns to 1 one cycle after the first pop.
- Pulse start at idx=400, and again during WAIT → both ignored, no restart, single result for the frame.
- Assert clear at idx=500, and separately drop up_rstn asynchronously mid-STREAM → FSM IDLE, FIFO empty, pixel_valid=0, result_valid=0. A following full frame completes correctly.
- Push 784+5 pixels, run two frames back-to-back starting from DONE → second frame begins at pixel 784 of the stream, result_valid drops on the second start and re-rises at the end of the second frame.
